// File: rtl/sp_pattern_sequencer.sv
// LFSR pattern sequencer for one-register-stage netlists: drives primary inputs,
// realigns the registered outputs to their patterns and counts ones per output.
module sp_pattern_sequencer #(
    parameter int          NUM_IN   = 5,
    parameter int          NUM_OUT  = 2,
    parameter int          PAT_W    = 16,
    parameter int          CNT_W    = 16,
    parameter int          PIPE_LAT = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [PAT_W-1:0]         num_patterns,
    input  logic [NUM_OUT-1:0]       dut_out,
    output logic [NUM_IN-1:0]        pat_out,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_OUT*CNT_W-1:0] ones_cnt,
    output logic [PAT_W-1:0]         sample_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [PAT_W-1:0]    num_q, num_d;
    logic [PAT_W-1:0]    issue_q, issue_d;
    logic [PAT_W-1:0]    sample_q, sample_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic [PIPE_LAT-1:0] drain_next;
    logic [CNT_W-1:0]    cnt_q [NUM_OUT];
    logic [CNT_W-1:0]    cnt_d [NUM_OUT];
    logic                push;
    logic                clear;
    logic                fb;

    // start is a level request honoured only in IDLE; there is no ready/ack,
    // busy and done tell the host whether it was taken.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        num_d      = num_q;
        issue_d    = issue_q;
        push       = 1'b0;
        clear      = 1'b0;
        fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        drain_next = PIPE_LAT'({pipe_q, 1'b0});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    issue_d = '0;
                    if (num_patterns != '0) begin
                        num_d   = num_patterns;
                        lfsr_d  = SEED_EFF;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                push    = 1'b1;
                lfsr_d  = {lfsr_q[14:0], fb};
                issue_d = issue_q + 1'b1;
                if (issue_d == num_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave once the last in-flight pattern reaches the tail.
                if (drain_next == '0) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        pipe_d = PIPE_LAT'({pipe_q, push});

        sample_d = sample_q;
        for (int i = 0; i < NUM_OUT; i++) cnt_d[i] = cnt_q[i];
        if (clear) begin
            sample_d = '0;
            for (int i = 0; i < NUM_OUT; i++) cnt_d[i] = '0;
        end else if (pipe_q[PIPE_LAT-1]) begin
            sample_d = sample_q + 1'b1;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (dut_out[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_EFF;
            num_q    <= '0;
            issue_q  <= '0;
            sample_q <= '0;
            pipe_q   <= '0;
            for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            num_q    <= num_d;
            issue_q  <= issue_d;
            sample_q <= sample_d;
            pipe_q   <= pipe_d;
            for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        ones_cnt = '0;
        for (int i = 0; i < NUM_OUT; i++) ones_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign pat_out    = (state_q == S_RUN) ? lfsr_q[NUM_IN-1:0] : '0;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign sample_cnt = sample_q;

endmodule

// File: tb/tb_sp_pattern_sequencer.sv
// Bench for sp_pattern_sequencer: two instances (latency 1 / 16-bit counters and
// latency 2 / 4-bit counters) checked every cycle against a run-level reference model.
module tb_sp_pattern_sequencer;

    localparam int MODE_RAND  = 0;
    localparam int MODE_CONST = 1;
    localparam int MODE_ECHO  = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [15:0] num;
    logic [1:0]  dout_a = 2'b00;
    logic [1:0]  dout_b = 2'b00;
    logic [4:0]  pat_a, pat_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] ones_a;
    logic [7:0]  ones_b;
    logic [15:0] samp_a, samp_b;

    always #5 clk = ~clk;

    sp_pattern_sequencer #(.NUM_IN(5), .NUM_OUT(2), .PAT_W(16), .CNT_W(16), .PIPE_LAT(1),
                           .SEED(16'hACE1)) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .num_patterns(num), .dut_out(dout_a),
        .pat_out(pat_a), .busy(busy_a), .done(done_a), .ones_cnt(ones_a), .sample_cnt(samp_a));

    sp_pattern_sequencer #(.NUM_IN(5), .NUM_OUT(2), .PAT_W(16), .CNT_W(4), .PIPE_LAT(2),
                           .SEED(16'hACE1)) dut_b (
        .clk(clk), .resetn(resetn), .start(start), .num_patterns(num), .dut_out(dout_b),
        .pat_out(pat_b), .busy(busy_b), .done(done_b), .ones_cnt(ones_b), .sample_cnt(samp_b));

    // Reference: a run is (start edge, N); every output follows from the edge offset m.
    logic [15:0] tab [0:1023];
    logic [1:0]  hist [2][0:1023];
    int          lat  [2] = '{1, 2};
    int          cmax [2] = '{65535, 15};
    bit          valid[2];
    int          e0   [2];
    int          nn   [2];
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    int          mode = MODE_RAND;
    logic [1:0]  cval = 2'b00;
    logic [4:0]  pa_cur, pb_cur;
    logic [1:0]  ea1 = 2'b00, eb1 = 2'b00, eb2 = 2'b00;
    logic        st_s, rn_s;
    logic [15:0] nm_s;

    logic [4:0]  fp [3];
    int          busy_na, busy_nb, done_na, done_nb, done_ma;

    function automatic int end_edge(input int d);
        return (nn[d] == 0) ? 0 : nn[d] + lat[d];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: bench-side netlist stand-in plus the model's view of accepted starts.
    initial begin
        forever begin
            @(negedge clk);
            pa_cur = pat_a;
            pb_cur = pat_b;
            @(posedge clk);
            st_s = start;
            nm_s = num;
            rn_s = resetn;
            #1;
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rn_s) valid[d] = 1'b0;
                else if (st_s && (!valid[d] || (cyc - e0[d] - 1) > end_edge(d))) begin
                    valid[d] = 1'b1;
                    e0[d]    = cyc;
                    nn[d]    = int'(nm_s);
                end
            end
            eb2 = eb1;
            eb1 = pb_cur[1:0];
            ea1 = pa_cur[1:0];
            case (mode)
                MODE_CONST: begin dout_a = cval; dout_b = cval; end
                MODE_ECHO:  begin dout_a = ea1;  dout_b = eb2;  end
                default:    begin dout_a = 2'($urandom); dout_b = 2'($urandom); end
            endcase
            if (valid[0] && (cyc - e0[0]) < 1024) hist[0][cyc - e0[0]] = dout_a;
            if (valid[1] && (cyc - e0[1]) < 1024) hist[1][cyc - e0[1]] = dout_b;
        end
    end

    task automatic check_dut(input int d, input logic [4:0] p, input logic b, input logic dn,
                             input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] s);
        int m, smp, sum0, sum1, n, l;
        logic [4:0] ep;
        logic eb, ed;
        n = nn[d];
        l = lat[d];
        ep = '0; eb = 1'b0; ed = 1'b0; smp = 0; sum0 = 0; sum1 = 0;
        if (resetn && valid[d]) begin
            m  = cyc - e0[d];
            eb = (n > 0) && (m < n + l);
            ed = (m == end_edge(d));
            if (n > 0 && m < n) ep = tab[m][4:0];
            smp = (n == 0 || m - l < 0) ? 0 : ((m - l > n) ? n : m - l);
            for (int k = 0; k < smp; k++) begin
                sum0 += int'(hist[d][k + l][0]);
                sum1 += int'(hist[d][k + l][1]);
            end
            if (sum0 > cmax[d]) sum0 = cmax[d];
            if (sum1 > cmax[d]) sum1 = cmax[d];
        end
        chk($sformatf("dut%0d pat_out", d), 32'(p), 32'(ep));
        chk($sformatf("dut%0d busy", d), 32'(b), 32'(eb));
        chk($sformatf("dut%0d done", d), 32'(dn), 32'(ed));
        chk($sformatf("dut%0d sample_cnt", d), 32'(s), smp);
        chk($sformatf("dut%0d ones_cnt0", d), 32'(o0), sum0);
        chk($sformatf("dut%0d ones_cnt1", d), 32'(o1), sum1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, pat_a, busy_a, done_a, ones_a[15:0], ones_a[31:16], samp_a);
            check_dut(1, pat_b, busy_b, done_b, {12'd0, ones_b[3:0]}, {12'd0, ones_b[7:4]}, samp_b);
        end
    end

    // Caller is 2 time units after a rising edge with both instances idle.
    task automatic run(input int n, input int md, input logic [1:0] cv, input int poke);
        mode  = md;
        cval  = cv;
        start = 1'b1;
        num   = 16'(n);
        @(posedge clk); #2;
        num     = 16'($urandom);
        busy_na = 0; busy_nb = 0; done_na = 0; done_nb = 0; done_ma = -1;
        for (int m = 0; m < n + 16; m++) begin
            start = (m == poke);
            if (m == poke) num = 16'($urandom_range(1, 5));
            @(negedge clk);
            if (m < 3) fp[m] = pat_a;
            busy_na += int'(busy_a);
            busy_nb += int'(busy_b);
            done_na += int'(done_a);
            done_nb += int'(done_b);
            if (done_a && done_ma < 0) done_ma = m;
            @(posedge clk); #2;
        end
        start = 1'b0;
    endtask

    initial begin
        int cnt0, cnt1, n, pk;
        resetn = 1'b0;
        start  = 1'b0;
        num    = '0;
        tab[0] = 16'hACE1;
        for (int i = 1; i < 1024; i++)
            tab[i] = {tab[i-1][14:0], tab[i-1][15] ^ tab[i-1][13] ^ tab[i-1][12] ^ tab[i-1][10]};

        repeat (3) @(posedge clk);
        #2;
        chk("reset pat_out", 32'(pat_a), 32'h0);
        chk("reset busy", 32'(busy_a), 32'h0);
        chk("reset sample_cnt", 32'(samp_a), 32'h0);
        chk("reset ones_cnt", ones_a, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #2;

        run(3, MODE_RAND, 2'b00, -1);
        chk("n3 pattern0", 32'(fp[0]), 32'h01);
        chk("n3 pattern1", 32'(fp[1]), 32'h03);
        chk("n3 pattern2", 32'(fp[2]), 32'h07);
        chk("n3 busy cycles lat1", busy_na, 4);
        chk("n3 busy cycles lat2", busy_nb, 5);
        chk("n3 done pulses", done_na, 1);
        chk("n3 sample_cnt", 32'(samp_a), 3);

        run(100, MODE_CONST, 2'b01, -1);
        chk("const ones0", 32'(ones_a[15:0]), 100);
        chk("const ones1", 32'(ones_a[31:16]), 0);
        chk("const sample_cnt", 32'(samp_a), 100);
        chk("const done cycle", done_ma + 1, 102);

        run(16, MODE_ECHO, 2'b00, -1);
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 16; k++) begin
            cnt0 += int'(tab[k][0]);
            cnt1 += int'(tab[k][1]);
        end
        chk("align lat1 bit0", 32'(ones_a[15:0]), cnt0);
        chk("align lat1 bit1", 32'(ones_a[31:16]), cnt1);
        chk("align lat2 bit0", 32'(ones_b[3:0]), (cnt0 > 15) ? 15 : cnt0);
        chk("align lat2 bit1", 32'(ones_b[7:4]), (cnt1 > 15) ? 15 : cnt1);

        run(20, MODE_CONST, 2'b11, -1);
        chk("sat ones", 32'(ones_b), 32'hFF);
        chk("sat sample_cnt", 32'(samp_b), 20);
        chk("nosat ones", ones_a, {16'd20, 16'd20});

        start = 1'b1;
        num   = 16'd50;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrun reset pat_out", 32'(pat_a), 32'h0);
        chk("midrun reset busy", 32'(busy_a), 32'h0);
        chk("midrun reset sample_cnt", 32'(samp_a), 32'h0);
        chk("midrun reset ones_cnt", ones_a, 32'h0);
        chk("midrun reset busy lat2", 32'(busy_b), 32'h0);
        @(posedge clk);
        @(posedge clk); #2;
        resetn = 1'b1;
        run(4, MODE_RAND, 2'b00, -1);
        chk("rerun sample_cnt", 32'(samp_a), 4);
        chk("rerun pattern0", 32'(fp[0]), 32'h01);

        run(0, MODE_RAND, 2'b00, -1);
        chk("n0 done pulses", done_na, 1);
        chk("n0 done cycle", done_ma, 0);
        chk("n0 busy cycles", busy_na + busy_nb, 0);
        chk("n0 sample_cnt", 32'(samp_a), 0);

        run(10, MODE_RAND, 2'b00, 5);
        chk("busy start sample_cnt", 32'(samp_a), 10);
        chk("busy start sample_cnt lat2", 32'(samp_b), 10);
        chk("busy start done pulses", done_na, 1);

        run(10, MODE_RAND, 2'b00, 11);
        chk("done-cycle start sample_cnt", 32'(samp_a), 10);
        chk("done-cycle start pulses", done_na, 1);

        run(8, MODE_RAND, 2'b00, 10);
        chk("first idle restart lat1", done_na, 2);
        chk("first idle restart lat2", done_nb, 1);

        for (int r = 0; r < 10; r++) begin
            n  = $urandom_range(1, 40);
            pk = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, n + 2);
            run(n, $urandom_range(0, 2), 2'($urandom), pk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
